// File: rtl/sc_fifo_pkg.sv
// Shared types and sizing helpers for the single-clock FIFO.
// Latency: n/a (compile-time only).
// Backpressure: n/a.
//
// Contents: read-mode enum, depth / occupancy-width helpers and the
// mapping from the integer SHOWAHEAD parameter onto the read-mode enum.
package sc_fifo_pkg;

   typedef enum logic {
      RD_NORMAL    = 1'b0,
      RD_SHOWAHEAD = 1'b1
   } rd_mode_e;

   // Number of words held by a FIFO with an awidth-bit address.
   function automatic int fifo_depth(input int awidth);
      return 1 << awidth;
   endfunction

   // The occupancy count must reach the full depth, so it needs one extra bit.
   function automatic int usedw_width(input int awidth);
      return awidth + 1;
   endfunction

   function automatic rd_mode_e rd_mode(input int showahead);
      return (showahead != 0) ? RD_SHOWAHEAD : RD_NORMAL;
   endfunction

endpackage

// File: rtl/sc_fifo_mem.sv
// Simple dual-port RAM, one write port and one read port on a single clock.
// Latency: write 1 cycle; read 1 cycle when REG_RD=1, combinational when REG_RD=0.
// Backpressure: none; the caller gates we_i/re_i.
//
// Ports:
//   clk_i            clock
//   srst_i           synchronous reset, clears only the read register
//   we_i/waddr_i/wdata_i   write port
//   re_i/raddr_i     read port (re_i loads the read register when REG_RD=1)
//   rdata_o          read data
// Storage itself is never cleared.
module sc_fifo_mem
   import sc_fifo_pkg::*;
#(
   parameter int DWIDTH = 16,
   parameter int AWIDTH = 8,
   parameter bit REG_RD = 1'b1
) (
   input  logic              clk_i,
   input  logic              srst_i,
   input  logic              we_i,
   input  logic [AWIDTH-1:0] waddr_i,
   input  logic [DWIDTH-1:0] wdata_i,
   input  logic              re_i,
   input  logic [AWIDTH-1:0] raddr_i,
   output logic [DWIDTH-1:0] rdata_o
);

   localparam int DEPTH = fifo_depth(AWIDTH);

   logic [DWIDTH-1:0] mem_q [DEPTH];

   always_ff @(posedge clk_i) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   generate
      if (REG_RD) begin : g_reg_rd
         logic [DWIDTH-1:0] rdata_q;

         // Output register holds its value between reads.
         always_ff @(posedge clk_i) begin
            if (srst_i) begin
               rdata_q <= '0;
            end else if (re_i) begin
               rdata_q <= mem_q[raddr_i];
            end
         end

         assign rdata_o = rdata_q;
      end else begin : g_async_rd
         logic unused_rd_ctrl;

         assign rdata_o        = mem_q[raddr_i];
         // Asynchronous read needs neither the enable nor the reset.
         assign unused_rd_ctrl = srst_i ^ re_i;
      end
   endgenerate

endmodule

// File: rtl/sc_fifo_flags.sv
// Single-clock FIFO with occupancy count, almost-full/almost-empty flags and normal or show-ahead read.
// Latency: write visible (empty_o low / show-ahead q_o) 1 cycle after wr_ok; normal-mode q_o 1 cycle after rd_ok.
// Backpressure: wrreq_i ignored while full_o, rdreq_i ignored while empty_o; nothing is stalled.
//
// Ports:
//   clk_i, srst_i            clock and synchronous active-high reset
//   data_i, wrreq_i          write side
//   rdreq_i, q_o             read side (rdreq_i is a read acknowledge in show-ahead mode)
//   empty_o, full_o          occupancy == 0 / == depth
//   usedw_o                  registered word count, 0..2**AWIDTH
//   almost_full_o            usedw_o >= ALMOST_FULL_VALUE
//   almost_empty_o           usedw_o <  ALMOST_EMPTY_VALUE
//   ovf_o, udf_o             sticky overflow / underflow attempt flags,
//                            present only when SC_FIFO_ERR_FLAGS_EN is defined
module sc_fifo_flags
   import sc_fifo_pkg::*;
#(
   parameter int DWIDTH             = 16,
   parameter int AWIDTH             = 8,
   parameter int ALMOST_FULL_VALUE  = (2 ** AWIDTH) - 2,
   parameter int ALMOST_EMPTY_VALUE = 2,
   parameter int SHOWAHEAD          = 0
) (
   input  logic              clk_i,
   input  logic              srst_i,
   input  logic [DWIDTH-1:0] data_i,
   input  logic              wrreq_i,
   input  logic              rdreq_i,
   output logic [DWIDTH-1:0] q_o,
   output logic              empty_o,
   output logic              full_o,
   output logic [AWIDTH:0]   usedw_o,
   output logic              almost_full_o,
   output logic              almost_empty_o
`ifdef SC_FIFO_ERR_FLAGS_EN
   ,
   output logic              ovf_o,
   output logic              udf_o
`endif
);

   localparam int       DEPTH   = fifo_depth(AWIDTH);
   localparam int       UW      = usedw_width(AWIDTH);
   localparam rd_mode_e RD_MODE = rd_mode(SHOWAHEAD);

   localparam logic [UW-1:0]   DEPTH_W = UW'(DEPTH);
   localparam logic [UW-1:0]   AF_W    = UW'(ALMOST_FULL_VALUE);
   localparam logic [UW-1:0]   AE_W    = UW'(ALMOST_EMPTY_VALUE);
   localparam logic [UW-1:0]   CNT_ONE = {{(UW-1){1'b0}}, 1'b1};
   localparam logic [AWIDTH:0] PTR_ONE = {{AWIDTH{1'b0}}, 1'b1};

   // Threshold sanity check at elaboration.
   generate
      if ((ALMOST_FULL_VALUE < 1) || (ALMOST_FULL_VALUE > DEPTH) ||
          (ALMOST_EMPTY_VALUE < 0) || (ALMOST_EMPTY_VALUE > DEPTH)) begin : g_param_err
         $error("sc_fifo_flags: almost-full/almost-empty threshold out of range");
      end
   endgenerate

   logic [AWIDTH:0] waddr_q, waddr_d;
   logic [AWIDTH:0] raddr_q, raddr_d;
   logic [UW-1:0]   usedw_q, usedw_d;
   logic            wr_ok;
   logic            rd_ok;

   // Requests qualify against flags from before the edge, so a simultaneous
   // read cannot make room for a write when full, and a write into an
   // empty FIFO is never passed straight through to a read.
   assign wr_ok = wrreq_i && !full_o;
   assign rd_ok = rdreq_i && !empty_o;

   always_comb begin
      waddr_d = waddr_q;
      raddr_d = raddr_q;
      usedw_d = usedw_q;
      if (wr_ok) begin
         waddr_d = waddr_q + PTR_ONE;
      end
      if (rd_ok) begin
         raddr_d = raddr_q + PTR_ONE;
      end
      case ({wr_ok, rd_ok})
         2'b10:   usedw_d = usedw_q + CNT_ONE;
         2'b01:   usedw_d = usedw_q - CNT_ONE;
         default: usedw_d = usedw_q;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (srst_i) begin
         waddr_q <= '0;
         raddr_q <= '0;
         usedw_q <= '0;
      end else begin
         waddr_q <= waddr_d;
         raddr_q <= raddr_d;
         usedw_q <= usedw_d;
      end
   end

   // Pointer MSBs only make the wrap explicit; occupancy comes from usedw_q.
   logic unused_ptr_msb;
   assign unused_ptr_msb = waddr_q[AWIDTH] ^ raddr_q[AWIDTH];

   // Flags are pure compares on the registered count.
   assign usedw_o        = usedw_q;
   assign empty_o        = (usedw_q == '0);
   assign full_o         = (usedw_q == DEPTH_W);
   assign almost_full_o  = (usedw_q >= AF_W);
   assign almost_empty_o = (usedw_q < AE_W);

   // Requests in a reset cycle must not touch memory either.
   sc_fifo_mem #(
      .DWIDTH (DWIDTH),
      .AWIDTH (AWIDTH),
      .REG_RD (RD_MODE == RD_NORMAL)
   ) u_mem (
      .clk_i   (clk_i),
      .srst_i  (srst_i),
      .we_i    (wr_ok && !srst_i),
      .waddr_i (waddr_q[AWIDTH-1:0]),
      .wdata_i (data_i),
      .re_i    (rd_ok && !srst_i),
      .raddr_i (raddr_q[AWIDTH-1:0]),
      .rdata_o (q_o)
   );

`ifdef SC_FIFO_ERR_FLAGS_EN
   logic ovf_q, ovf_d;
   logic udf_q, udf_d;

   // Sticky until reset.
   always_comb begin
      ovf_d = ovf_q | (wrreq_i & full_o);
      udf_d = udf_q | (rdreq_i & empty_o);
   end

   always_ff @(posedge clk_i) begin
      if (srst_i) begin
         ovf_q <= 1'b0;
         udf_q <= 1'b0;
      end else begin
         ovf_q <= ovf_d;
         udf_q <= udf_d;
      end
   end

   assign ovf_o = ovf_q;
   assign udf_o = udf_q;
`endif

endmodule

// File: tb/tb_sc_fifo_flags.sv
// Bench for sc_fifo_flags: one normal-mode and one show-ahead instance
// driven by identical stimulus and checked against a queue model.
module tb_sc_fifo_flags;

   localparam int DW = 16;
   localparam int AW = 3;
   localparam int DEPTH = 8;
   localparam int AFV = 6;
   localparam int AEV = 2;

   logic          clk = 1'b0;
   logic          srst;
   logic [DW-1:0] data;
   logic          wrreq;
   logic          rdreq;

   logic [DW-1:0] q_n, q_s;
   logic          empty_n, empty_s, full_n, full_s;
   logic [AW:0]   usedw_n, usedw_s;
   logic          af_n, af_s, ae_n, ae_s;
`ifdef SC_FIFO_ERR_FLAGS_EN
   logic          ovf_n, udf_n, ovf_s, udf_s;
`endif

   always #5 clk = ~clk;

   sc_fifo_flags #(
      .DWIDTH(DW), .AWIDTH(AW), .ALMOST_FULL_VALUE(AFV),
      .ALMOST_EMPTY_VALUE(AEV), .SHOWAHEAD(0)
   ) u_norm (
      .clk_i(clk), .srst_i(srst), .data_i(data), .wrreq_i(wrreq), .rdreq_i(rdreq),
      .q_o(q_n), .empty_o(empty_n), .full_o(full_n), .usedw_o(usedw_n),
      .almost_full_o(af_n), .almost_empty_o(ae_n)
`ifdef SC_FIFO_ERR_FLAGS_EN
      , .ovf_o(ovf_n), .udf_o(udf_n)
`endif
   );

   sc_fifo_flags #(
      .DWIDTH(DW), .AWIDTH(AW), .ALMOST_FULL_VALUE(AFV),
      .ALMOST_EMPTY_VALUE(AEV), .SHOWAHEAD(1)
   ) u_sa (
      .clk_i(clk), .srst_i(srst), .data_i(data), .wrreq_i(wrreq), .rdreq_i(rdreq),
      .q_o(q_s), .empty_o(empty_s), .full_o(full_s), .usedw_o(usedw_s),
      .almost_full_o(af_s), .almost_empty_o(ae_s)
`ifdef SC_FIFO_ERR_FLAGS_EN
      , .ovf_o(ovf_s), .udf_o(udf_s)
`endif
   );

   int total = 0;
   int bad   = 0;
   bit chk_en = 1'b0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   logic [DW-1:0] mq[$];
   logic [DW-1:0] m_q = '0;
   bit            m_ovf = 1'b0;
   bit            m_udf = 1'b0;
   bit            m_full, m_empty;

   always @(posedge clk) begin
      if (srst) begin
         mq.delete();
         m_q   = '0;
         m_ovf = 1'b0;
         m_udf = 1'b0;
      end else begin
         m_full  = (mq.size() == DEPTH);
         m_empty = (mq.size() == 0);
         if (wrreq && m_full)  m_ovf = 1'b1;
         if (rdreq && m_empty) m_udf = 1'b1;
         if (rdreq && !m_empty) m_q = mq.pop_front();
         if (wrreq && !m_full)  mq.push_back(data);
      end
   end

   // ---------------- per-cycle compare ----------------
   int n_c;
   always @(negedge clk) begin
      if (chk_en) begin
         n_c = mq.size();
         chk("usedw_n", 32'(usedw_n), 32'(n_c));
         chk("usedw_s", 32'(usedw_s), 32'(n_c));
         chk("empty_n", 32'(empty_n), 32'(n_c == 0));
         chk("empty_s", 32'(empty_s), 32'(n_c == 0));
         chk("full_n",  32'(full_n),  32'(n_c == DEPTH));
         chk("full_s",  32'(full_s),  32'(n_c == DEPTH));
         chk("af_n",    32'(af_n),    32'(n_c >= AFV));
         chk("af_s",    32'(af_s),    32'(n_c >= AFV));
         chk("ae_n",    32'(ae_n),    32'(n_c < AEV));
         chk("ae_s",    32'(ae_s),    32'(n_c < AEV));
         chk("q_norm",  32'(q_n),     32'(m_q));
         if (n_c > 0) chk("q_showahead", 32'(q_s), 32'(mq[0]));
`ifdef SC_FIFO_ERR_FLAGS_EN
         chk("ovf_n", 32'(ovf_n), 32'(m_ovf));
         chk("udf_n", 32'(udf_n), 32'(m_udf));
         chk("ovf_s", 32'(ovf_s), 32'(m_ovf));
         chk("udf_s", 32'(udf_s), 32'(m_udf));
`endif
      end
   end

   // One clock: drive at a falling edge, return at the next falling edge.
   task automatic step(input logic w, input logic r, input logic [DW-1:0] d, input logic s);
      wrreq = w;
      rdreq = r;
      data  = d;
      srst  = s;
      @(negedge clk);
   endtask

   int pw, pr;

   initial begin
      srst  = 1'b1;
      wrreq = 1'b0;
      rdreq = 1'b0;
      data  = '0;
      @(negedge clk);
      chk_en = 1'b1;
      step(1'b0, 1'b0, 16'h0, 1'b0);

      // reset state, literal
      chk("rst_usedw", 32'(usedw_n), 32'd0);
      chk("rst_empty", 32'(empty_n), 32'd1);
      chk("rst_ae",    32'(ae_n),    32'd1);
      chk("rst_full",  32'(full_n),  32'd0);
      chk("rst_af",    32'(af_n),    32'd0);
      chk("rst_q",     32'(q_n),     32'd0);

      // fill to full, then one dropped write
      for (int i = 1; i <= 8; i++) begin
         step(1'b1, 1'b0, 16'(i), 1'b0);
         chk("fill_usedw", 32'(usedw_n), 32'(i));
         chk("fill_af",    32'(af_n),    32'(i >= 6));
         chk("fill_full",  32'(full_n),  32'(i == 8));
      end
      step(1'b1, 1'b0, 16'h0009, 1'b0);
      chk("ovf_usedw", 32'(usedw_n), 32'd8);
      chk("ovf_full",  32'(full_n),  32'd1);
`ifdef SC_FIFO_ERR_FLAGS_EN
      chk("ovf_flag", 32'(ovf_n), 32'd1);
`endif

      // drain in normal mode, then an underflow attempt
      for (int i = 1; i <= 8; i++) begin
         step(1'b0, 1'b1, 16'h0, 1'b0);
         chk("drain_q", 32'(q_n), 32'(i));
      end
      chk("drain_empty", 32'(empty_n), 32'd1);
      step(1'b0, 1'b1, 16'h0, 1'b0);
      chk("udf_q_hold", 32'(q_n), 32'h0008);
`ifdef SC_FIFO_ERR_FLAGS_EN
      chk("udf_flag", 32'(udf_n), 32'd1);
`endif

      // show-ahead: written word appears the cycle after the write
      step(1'b1, 1'b0, 16'hABCD, 1'b0);
      chk("sa_empty", 32'(empty_s), 32'd0);
      chk("sa_q",     32'(q_s),     32'hABCD);
      step(1'b0, 1'b1, 16'h0, 1'b0);
      chk("sa_pop_empty", 32'(empty_s), 32'd1);
      chk("sa_pop_qn",    32'(q_n),     32'hABCD);

      // four words, then 10 cycles of concurrent write+read across pointer wrap
      for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 16'(16'h0100 + i), 1'b0);
      for (int k = 0; k < 10; k++) begin
         step(1'b1, 1'b1, 16'(16'h0200 + k), 1'b0);
         chk("rw_usedw", 32'(usedw_n), 32'd4);
         chk("rw_q", 32'(q_n), (k < 4) ? 32'(16'h0100 + k) : 32'(16'h0200 + k - 4));
      end

      // reset while holding 5 words with a concurrent write
      step(1'b1, 1'b0, 16'h0300, 1'b0);
      chk("pre_rst_usedw", 32'(usedw_n), 32'd5);
      step(1'b1, 1'b0, 16'h0301, 1'b1);
      chk("mid_rst_usedw", 32'(usedw_n), 32'd0);
      chk("mid_rst_empty", 32'(empty_n), 32'd1);
      chk("mid_rst_ae",    32'(ae_n),    32'd1);
      chk("mid_rst_q",     32'(q_n),     32'd0);
      step(1'b0, 1'b0, 16'h0, 1'b0);
      chk("post_rst_usedw", 32'(usedw_n), 32'd0);
`ifdef SC_FIFO_ERR_FLAGS_EN
      chk("post_rst_ovf", 32'(ovf_n), 32'd0);
      chk("post_rst_udf", 32'(udf_n), 32'd0);
`endif

      // randomized phases with varying write/read pressure and rare resets
      pw = 50;
      pr = 50;
      for (int c = 0; c < 3000; c++) begin
         if (c % 250 == 0) begin
            pw = int'($urandom_range(10, 90));
            pr = int'($urandom_range(10, 90));
         end
         step(32'($urandom_range(0, 99)) < 32'(pw),
              32'($urandom_range(0, 99)) < 32'(pr),
              16'($urandom),
              $urandom_range(0, 299) == 0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
